player_exec: RTL

PLAYER_EXEC -- requirements
Module: player_exec

---
 rtl/player_exec.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/player_exec.sv
// Player execution unit: applies HP/position instructions through an ALIVE/HIT/DEAD FSM.
// Every output is a register; HPY/DPY fire once per distinct instruction word.
module player_exec #(
    parameter logic [7:0]  MAX_HP   = 8'd100,
    parameter logic [9:0]  X_MIN    = 10'd200,
    parameter logic [9:0]  X_MAX    = 10'd440,
    parameter logic [9:0]  Y_MIN    = 10'd240,
    parameter logic [9:0]  Y_MAX    = 10'd400,
    parameter logic [9:0]  STEP     = 10'd4,
    parameter logic [19:0] MOVE_DIV = 20'd250000,
    parameter logic [23:0] IFRAME   = 24'd5000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] playerInstruction,
    input  logic        isMove,
    output logic [7:0]  playerHP,
    output logic [9:0]  posX,
    output logic [9:0]  posY,
    output logic        isDeath,
    output logic        isDmgComplete,
    output logic        invuln
);
    typedef enum logic [1:0] {ALIVE, HIT, DEAD} state_t;

    localparam logic [3:0] OP_HPY = 4'd1;
    localparam logic [3:0] OP_DPY = 4'd2;
    localparam logic [3:0] OP_IDG = 4'd3;
    localparam logic [3:0] OP_MOV = 4'd5;
    localparam logic [3:0] OP_SHP = 4'd6;

    // Centre computed in 11 bits so the limit sum cannot wrap.
    localparam logic [10:0] X_SUM = {1'b0, X_MIN} + {1'b0, X_MAX};
    localparam logic [10:0] Y_SUM = {1'b0, Y_MIN} + {1'b0, Y_MAX};
    localparam logic [9:0]  X_CTR = X_SUM[10:1];
    localparam logic [9:0]  Y_CTR = Y_SUM[10:1];

    state_t       state_q, state_d;
    logic [7:0]   hp_q, hp_d;
    logic [9:0]   x_q, x_d, y_q, y_d;
    logic [15:0]  last_q, last_d;
    logic [23:0]  icnt_q, icnt_d;
    logic [19:0]  mcnt_q, mcnt_d;
    logic         dmg_q, dmg_d;
    logic         death_q, death_d;
    logic         inv_q, inv_d;

    logic [3:0]   op;
    logic [7:0]   operand;
    logic         is_hd, new_word, mov_run, tick;
    logic [8:0]   heal_sum;
    logic [7:0]   heal_hp, dmg_hp, shp_hp;
    logic [10:0]  x_inc, y_inc, x_lo, y_lo;

    assign op       = playerInstruction[15:12];
    assign operand  = playerInstruction[11:4];
    assign is_hd    = (op == OP_HPY) || (op == OP_DPY);
    assign new_word = is_hd && (playerInstruction != last_q);
    assign mov_run  = isMove && (op == OP_MOV);
    assign tick     = mov_run && (mcnt_q == MOVE_DIV - 20'd1);

    assign heal_sum = {1'b0, hp_q} + {1'b0, operand};
    assign heal_hp  = (heal_sum > {1'b0, MAX_HP}) ? MAX_HP : heal_sum[7:0];
    assign dmg_hp   = (hp_q > operand) ? hp_q - operand : 8'd0;
    assign shp_hp   = (operand > MAX_HP) ? MAX_HP : operand;

    assign x_inc = {1'b0, x_q} + {1'b0, STEP};
    assign y_inc = {1'b0, y_q} + {1'b0, STEP};
    assign x_lo  = {1'b0, X_MIN} + {1'b0, STEP};
    assign y_lo  = {1'b0, Y_MIN} + {1'b0, STEP};

    always_comb begin
        state_d = state_q;
        hp_d    = hp_q;
        x_d     = x_q;
        y_d     = y_q;
        icnt_d  = icnt_q;
        dmg_d   = 1'b0;
        last_d  = is_hd ? last_q : 16'd0;
        mcnt_d  = (!mov_run || tick) ? 20'd0 : mcnt_q + 20'd1;

        if (state_q == HIT) begin
            if (icnt_q == 24'd0) state_d = ALIVE;
            else                 icnt_d  = icnt_q - 24'd1;
        end

        case (op)
            OP_HPY: if (new_word && state_q != DEAD) begin
                last_d = playerInstruction;
                dmg_d  = 1'b1;
                hp_d   = heal_hp;
            end
            OP_DPY: if (new_word && state_q != DEAD) begin
                last_d = playerInstruction;
                dmg_d  = 1'b1;
                // Damage during HIT is consumed but absorbed by the iframes.
                if (state_q == ALIVE) begin
                    hp_d = dmg_hp;
                    if (dmg_hp == 8'd0) begin
                        state_d = DEAD;
                    end else begin
                        state_d = HIT;
                        icnt_d  = IFRAME - 24'd1;
                    end
                end
            end
            OP_IDG: begin
                hp_d    = MAX_HP;
                x_d     = X_CTR;
                y_d     = Y_CTR;
                state_d = ALIVE;
                icnt_d  = 24'd0;
            end
            OP_MOV: if (tick && state_q != DEAD) begin
                case (operand)
                    8'd0: y_d = ({1'b0, y_q} < y_lo) ? Y_MIN : y_q - STEP;
                    8'd1: x_d = (x_inc > {1'b0, X_MAX}) ? X_MAX : x_inc[9:0];
                    8'd2: y_d = (y_inc > {1'b0, Y_MAX}) ? Y_MAX : y_inc[9:0];
                    8'd3: x_d = ({1'b0, x_q} < x_lo) ? X_MIN : x_q - STEP;
                    default: ;
                endcase
            end
            OP_SHP: if (state_q != DEAD) begin
                hp_d = shp_hp;
                if (operand == 8'd0) begin
                    state_d = DEAD;
                    icnt_d  = 24'd0;
                end
            end
            default: ;
        endcase

        death_d = (state_d == DEAD);
        inv_d   = (state_d == HIT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ALIVE;
            hp_q    <= MAX_HP;
            x_q     <= X_CTR;
            y_q     <= Y_CTR;
            last_q  <= 16'd0;
            icnt_q  <= 24'd0;
            mcnt_q  <= 20'd0;
            dmg_q   <= 1'b0;
            death_q <= 1'b0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hp_q    <= hp_d;
            x_q     <= x_d;
            y_q     <= y_d;
            last_q  <= last_d;
            icnt_q  <= icnt_d;
            mcnt_q  <= mcnt_d;
            dmg_q   <= dmg_d;
            death_q <= death_d;
            inv_q   <= inv_d;
        end
    end

    assign playerHP      = hp_q;
    assign posX          = x_q;
    assign posY          = y_q;
    assign isDeath       = death_q;
    assign isDmgComplete = dmg_q;
    assign invuln        = inv_q;
endmodule
